key_sched: RTL and testbench
============================

Name: key_sched

Overview:
- Sequential Twofish 128-bit key expansion engine.
- Latches a 128-bit user key and iterates the subkey-pair index i = 0..19 through the existing combinational kBox stage.
- Stores the 40 expanded round subkeys K0..K39 in an internal register file.
- Downstream round logic (whitening and per-round F-function) reads subkeys through a registered read port.

Parameters:
- NUM_PAIRS, 20, number of subkey pairs generated; fixed at 20 for Twofish.
- IDX_W, 6, width of the subkey read index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request key expansion; sampled only when not busy.
- key  input  128  user key; word j = key[32j+31:32j], mapped to kBox m0..m3 for j = 0..3.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse after the last subkey pair is written.
- keys_valid  output  1  all 40 subkeys valid; held high until the next accepted start.
- rd_idx  input  IDX_W  subkey index to read, 0..39.
- rd_data  output  32  subkey K[rd_idx], registered.

Behaviour:
- Reset (rst_n low at a clk edge, synchronous):
  - busy = 0, done = 0, keys_valid = 0, rd_data = 0, state = IDLE, counter = 0.
  - The subkey array is not reset.
- States:
  - IDLE: start = 1 latches key into m0..m3, clears counter and keys_valid, and goes to GEN.
  - GEN:
    - Each cycle, kBox is fed i = counter.
    - The edge writes K[2i] = ao and K[2i+1] = bo, then increments counter.
    - When counter = NUM_PAIRS-1, that write completes and the FSM goes to DONE.
  - DONE:
    - done = 1 for exactly one cycle (the first cycle in DONE); keys_valid = 1 from that same cycle.
    - Returns to IDLE on the following cycle.
- Latency: start accepted at edge 0; pairs are written on edges 1..20; done and keys_valid are high in the cycle after edge 20. Total: 21 cycles start-to-done.
- busy = 1 in GEN and DONE, and 0 in IDLE.
- start while busy is ignored; the latched key is unchanged and no restart occurs.
- start in the same cycle done is high is ignored. It is accepted on the next cycle (IDLE).
- A new accepted start drops keys_valid the following cycle. Old subkeys remain readable but are not guaranteed until the next done.
- Read port:
  - rd_data <= K[rd_idx] on every edge, independent of state (1-cycle latency).
  - rd_idx >= 40 yields rd_data = 0.
  - Reading an index being written in the same cycle returns the old value (no bypass).
- Counter width: 5 bits. It never exceeds NUM_PAIRS-1; there is no wrap-around.
- Reset asserted mid-GEN aborts expansion: keys_valid = 0 and no done pulse.
- Arithmetic: all kBox arithmetic is mod 2^32 inside kBox; kBox receives i as 8 bits, zero-extended from the counter.

Optional Feature:
- Macro: KEY_SCHED_DUAL_EN.
- Defined:
  - Two kBox instances compute pairs i and i+1 (i even) in the same cycle, writing 4 subkeys per edge.
  - GEN lasts 10 cycles; start-to-done is 11 cycles.
  - The counter steps by 2.
- Undefined: single instance, 20 GEN cycles, as described above.
- Interface and read behaviour are identical in both builds.

Decomposition:
- Shared package twofish_pkg holds:
  - NUM_SUBKEYS = 40 and NUM_PAIRS = 20.
  - Typedef word_t (logic [31:0]).
  - Typedef subkey_idx_t (logic [5:0]).
  - Typedef ks_state_t enum {IDLE, GEN, DONE}.
- Sub-module: the existing kBox, instantiated once (twice under KEY_SCHED_DUAL_EN).
- The FSM, counter, and register file live in key_sched itself.

Test Plan:
- Reset held 3 cycles, then released → busy = 0, done = 0, keys_valid = 0, rd_data = 0.
- Zero key, start pulse → done high exactly 21 cycles after start (11 with KEY_SCHED_DUAL_EN). Then:
  - rd_idx = 0..3 returns 52C54DDE, 11F0626D, 7CAC9D4A, 4D1B4AAA.
  - All 40 entries match the golden model.
- start pulsed at GEN cycle 5 with a different key → ignored; results still match the original key.
- Reset asserted at GEN cycle 10 → keys_valid stays 0 and no done pulse. A subsequent start completes normally.
- rd_idx = 40 and rd_idx = 63 → rd_data = 0 one cycle later.
- Back-to-back: start on the cycle after done with a new key → keys_valid falls, then rises with the new subkeys; done pulses once per expansion.

Source files
------------

// File: rtl/twofish_pkg.sv
// Shared Twofish key-schedule types and sizes.
package twofish_pkg;

    localparam int unsigned NUM_SUBKEYS = 40;
    localparam int unsigned NUM_PAIRS   = 20;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned CNT_W       = 5;

    typedef logic [31:0]       word_t;
    typedef logic [IDX_W-1:0]  subkey_idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {IDLE, GEN, DONE} ks_state_t;

    function automatic word_t rol32(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/key_sched_kbox.sv
// Twofish subkey-pair generator (kBox): K[2i] and K[2i+1] from the four key words.
module key_sched_kbox
    import twofish_pkg::*;
(
    input  logic [7:0] idx_i,
    input  word_t      m0_i,
    input  word_t      m1_i,
    input  word_t      m2_i,
    input  word_t      m3_i,
    output word_t      ao_o,
    output word_t      bo_o
);

    // q0/q1 nibble tables t0..t3, entry n at bits [4n+3:4n]
    localparam logic [63:0] QT [2][4] = '{
        '{64'h4ACE95B023F6D718, 64'hD9076A4F53218BCE,
          64'h17423F8C09D6E5AB, 64'hAC5803B9E6214F7D},
        '{64'h5CA04913E67FDB82, 64'h809F5AD673C4B2E1,
          64'hF3B28DE0A96157C4, 64'hA802F746ED3C159B}
    };

    function automatic logic [7:0] qp(input logic sel, input logic [7:0] x);
        logic [3:0] a, b, ta, tb;
        a  = x[7:4];
        b  = x[3:0];
        ta = a ^ b;
        tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = QT[sel][0][{ta, 2'b00} +: 4];
        b  = QT[sel][1][{tb, 2'b00} +: 4];
        ta = a ^ b;
        tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a  = QT[sel][2][{ta, 2'b00} +: 4];
        b  = QT[sel][3][{tb, 2'b00} +: 4];
        return {b, a};
    endfunction

    // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1
    function automatic logic [7:0] gm(input logic [7:0] c, input logic [7:0] v);
        logic [7:0] p, s;
        p = 8'h00;
        s = v;
        for (int k = 0; k < 8; k++) begin
            if (c[k]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h69 : 8'h00);
        end
        return p;
    endfunction

    function automatic word_t h_fn(input logic [7:0] x, input word_t l0, input word_t l1);
        logic [7:0] y0, y1, y2, y3;
        y0 = qp(1'b1, qp(1'b0, qp(1'b0, x) ^ l1[7:0])   ^ l0[7:0]);
        y1 = qp(1'b0, qp(1'b0, qp(1'b1, x) ^ l1[15:8])  ^ l0[15:8]);
        y2 = qp(1'b1, qp(1'b1, qp(1'b0, x) ^ l1[23:16]) ^ l0[23:16]);
        y3 = qp(1'b0, qp(1'b1, qp(1'b1, x) ^ l1[31:24]) ^ l0[31:24]);
        return {gm(8'hEF, y0) ^ y1              ^ gm(8'hEF, y2) ^ gm(8'h5B, y3),
                gm(8'hEF, y0) ^ gm(8'h5B, y1)   ^ y2            ^ gm(8'hEF, y3),
                gm(8'h5B, y0) ^ gm(8'hEF, y1)   ^ gm(8'hEF, y2) ^ y3,
                y0            ^ gm(8'hEF, y1)   ^ gm(8'h5B, y2) ^ gm(8'h5B, y3)};
    endfunction

    logic [7:0] xa, xb;
    word_t      a, b;

    always_comb begin
        xa   = idx_i << 1;
        xb   = xa | 8'd1;
        a    = h_fn(xa, m0_i, m2_i);
        b    = rol32(h_fn(xb, m1_i, m3_i), 8);
        ao_o = a + b;
        bo_o = rol32(a + (b << 1), 9);
    end

endmodule

// File: rtl/key_sched.sv
// Sequential Twofish 128-bit key expansion with a registered subkey read port.
// KEY_SCHED_DUAL_EN: two kBox instances, four subkeys per cycle.
module key_sched
    import twofish_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [127:0]  key,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  subkey_idx_t   rd_idx,
    output logic [31:0]   rd_data
);

`ifdef KEY_SCHED_DUAL_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif
    localparam cnt_t CNT_LAST = cnt_t'(NUM_PAIRS - STEP);
    localparam cnt_t CNT_STEP = cnt_t'(STEP);

    ks_state_t     state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic [127:0]  key_q, key_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          kv_q, kv_d;
    word_t         rd_data_q, rd_data_d;
    word_t         kreg_q [NUM_SUBKEYS];
    word_t         ao0, bo0;

    key_sched_kbox u_kbox0 (
        .idx_i (8'({3'b000, cnt_q})),
        .m0_i  (key_q[31:0]),
        .m1_i  (key_q[63:32]),
        .m2_i  (key_q[95:64]),
        .m3_i  (key_q[127:96]),
        .ao_o  (ao0),
        .bo_o  (bo0)
    );

`ifdef KEY_SCHED_DUAL_EN
    word_t ao1, bo1;

    key_sched_kbox u_kbox1 (
        .idx_i (8'({3'b000, cnt_q + 5'd1})),
        .m0_i  (key_q[31:0]),
        .m1_i  (key_q[63:32]),
        .m2_i  (key_q[95:64]),
        .m3_i  (key_q[127:96]),
        .ao_o  (ao1),
        .bo_o  (bo1)
    );
`endif

    // Next-state, counter and status flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        kv_d    = kv_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    cnt_d   = '0;
                    kv_d    = 1'b0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_STEP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        rd_data_d = (rd_idx < subkey_idx_t'(NUM_SUBKEYS)) ? kreg_q[rd_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            kv_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            kv_q      <= kv_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Key latch and subkey storage carry no reset
    always_ff @(posedge clk) begin
        key_q <= key_d;
        if (rst_n && state_q == GEN) begin
            kreg_q[{cnt_q, 1'b0}] <= ao0;
            kreg_q[{cnt_q, 1'b1}] <= bo0;
`ifdef KEY_SCHED_DUAL_EN
            kreg_q[{cnt_q, 1'b0} + 6'd2] <= ao1;
            kreg_q[{cnt_q, 1'b0} + 6'd3] <= bo1;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_key_sched.sv
// Scoreboard bench for key_sched against a Twofish key-schedule reference model.
module tb_key_sched;

`ifdef KEY_SCHED_DUAL_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 21;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [5:0]   rd_idx = 6'd40;
    logic         busy, done, keys_valid;
    logic [31:0]  rd_data;

    key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: q permutations built from the nibble tables, h, MDS, PHT
    localparam logic [63:0] QN [2][4] = '{
        '{64'h4ACE95B023F6D718, 64'hD9076A4F53218BCE,
          64'h17423F8C09D6E5AB, 64'hAC5803B9E6214F7D},
        '{64'h5CA04913E67FDB82, 64'h809F5AD673C4B2E1,
          64'hF3B28DE0A96157C4, 64'hA802F746ED3C159B}
    };
    localparam int MDS [4][4] = '{'{1, 'hEF, 'h5B, 'h5B}, '{'h5B, 'hEF, 'hEF, 1},
                                  '{'hEF, 'h5B, 1, 'hEF}, '{'hEF, 1, 'hEF, 'h5B}};
    int          qtab [2][256];
    logic [31:0] model_k [40];

    function automatic int nib(input int s, input int t, input int n);
        return int'((QN[s][t] >> (4 * n)) & 64'hF);
    endfunction

    function automatic int qcalc(input int s, input int x);
        int a, b, ta, tb;
        a = x / 16;
        b = x % 16;
        for (int r = 0; r < 2; r++) begin
            ta = a ^ b;
            tb = (a ^ (((b >> 1) | (b << 3)) & 15) ^ ((a * 8) % 16));
            a  = nib(s, 2 * r, ta);
            b  = nib(s, 2 * r + 1, tb);
        end
        return b * 16 + a;
    endfunction

    function automatic int gmul(input int a, input int b);
        int p, aa;
        p = 0;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (((b >> k) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h169;
        end
        return p;
    endfunction

    function automatic logic [31:0] h_ref(input int x, input logic [31:0] l0, input logic [31:0] l1);
        int y [4];
        int v, zi;
        logic [31:0] z;
        z = '0;
        for (int j = 0; j < 4; j++) begin
            v = qtab[j % 2][x];
            v = qtab[j / 2][v ^ int'(l1[8*j +: 8])];
            v = qtab[1 - j % 2][v ^ int'(l0[8*j +: 8])];
            y[j] = v;
        end
        for (int i = 0; i < 4; i++) begin
            zi = 0;
            for (int j = 0; j < 4; j++) zi = zi ^ gmul(MDS[i][j], y[j]);
            z[8*i +: 8] = 8'(zi);
        end
        return z;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic expand_ref(input logic [127:0] k);
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = h_ref(2 * i, k[31:0], k[95:64]);
            b = rol(h_ref(2 * i + 1, k[63:32], k[127:96]), 8);
            model_k[2*i]   = a + b;
            model_k[2*i+1] = rol(a + (b << 1), 9);
        end
    endtask

    // Scoreboard queues
    logic [31:0] rd_exp_q [$];
    int          rd_tag_q [$];
    int          done_q [$];
    logic        rd_issue = 1'b0;

    initial begin : rd_monitor
        logic        pend;
        logic [31:0] e;
        int          t;
        forever begin
            @(posedge clk);
            pend = rd_issue;
            @(negedge clk);
            if (pend) begin
                n_chk++;
                if (rd_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_queue: read returned %08h with nothing expected", rd_data);
                end else begin
                    e = rd_exp_q.pop_front();
                    t = rd_tag_q.pop_front();
                    if (rd_data !== e) begin
                        n_fail++;
                        $display("FAIL rd_data[%0d]: got %08h expected %08h", t, rd_data, e);
                    end
                end
            end
        end
    end

    initial begin : done_monitor
        int e;
        forever begin
            @(negedge clk);
            if (done !== 1'b0) begin
                n_chk++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_pulse: done=%b at cycle %0d with no expansion pending", done, cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc != e || done !== 1'b1) begin
                        n_fail++;
                        $display("FAIL done_cycle: done=%b at cycle %0d expected at cycle %0d", done, cyc, e);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic issue_read(input int idx, input logic [31:0] expv);
        rd_idx   = 6'(idx);
        rd_issue = 1'b1;
        rd_exp_q.push_back(expv);
        rd_tag_q.push_back(idx);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 40; i++) issue_read(i, model_k[i]);
    endtask

    task automatic do_start(input logic [127:0] k, input bit expect_done);
        key   = k;
        start = 1'b1;
        if (expect_done) begin
            expand_ref(k);
            done_q.push_back(cyc + LAT);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_kv(input string nm);
        int t;
        t = 0;
        while (keys_valid !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (keys_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: keys_valid=%b after %0d cycles", nm, keys_valid, t);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : stimulus
        logic [127:0] ka;
        int           ri;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 256; x++) qtab[s][x] = qcalc(s, x);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_keys_valid", 32'(keys_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);

        // Zero key, golden values, done-cycle start ignored
        @(negedge clk);
        do_start('0, 1'b1);
        check("gen_busy", 32'(busy), 32'd1);
        check("gen_keys_valid", 32'(keys_valid), 32'd0);
        wait_kv("zero_key");
        key   = rand_key();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_start_ignored_busy", 32'(busy), 32'd0);
        check("done_start_keys_valid", 32'(keys_valid), 32'd1);
        issue_read(0, 32'h52C54DDE);
        issue_read(1, 32'h11F0626D);
        issue_read(2, 32'h7CAC9D4A);
        issue_read(3, 32'h4D1B4AAA);
        read_all();
        issue_read(40, 32'd0);
        issue_read(63, 32'd0);

        // Start while busy is ignored
        ka = rand_key();
        do_start(ka, 1'b1);
        repeat (4) @(negedge clk);
        key   = rand_key();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = '0;
        wait_kv("busy_start");
        @(negedge clk);
        read_all();

        // Reset mid-expansion aborts, then a clean restart completes
        ka = rand_key();
        do_start(ka, 1'b0);
        repeat (LAT / 2 - 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_keys_valid", 32'(keys_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (LAT + 4) @(negedge clk);
        check("abort_keys_valid_late", 32'(keys_valid), 32'd0);
        do_start(ka, 1'b1);
        wait_kv("restart");
        @(negedge clk);
        read_all();

        // Back-to-back expansions
        do_start(rand_key(), 1'b1);
        wait_kv("b2b_first");
        @(negedge clk);
        do_start(rand_key(), 1'b1);
        check("b2b_keys_valid_drop", 32'(keys_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_kv("b2b_second");
        @(negedge clk);
        read_all();

        // Random read addresses including out-of-range
        for (int n = 0; n < 24; n++) begin
            ri = int'($urandom_range(0, 63));
            issue_read(ri, (ri < 40) ? model_k[ri] : 32'd0);
        end

        repeat (LAT + 4) @(negedge clk);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
